ripple_count_monitor: RTL and testbench
=======================================

# ripple_count_monitor

Downstream consumer of the 4-bit ripple up-counter. Ripple counters settle bit by bit, so their outputs are not safe to sample directly. This block resamples the counter value into the system clock domain and accepts a new value only once it is glitch-free. It then flags a programmable target match through an arm/hit state machine and optionally counts 15→0 wrap-arounds for the rest of the lab design.

## Interface
Parameters:
- WIDTH, 4, width of the monitored count
- SYNC_STAGES, 2, flip-flop synchronizer depth (minimum 2)
- WRAP_CNT_W, 8, width of the wrap event counter

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset; clears all state immediately
- count_in  input  WIDTH  raw ripple-counter output (out of the upstream counter)
- target  input  WIDTH  match value; sampled on the cycle arm is seen
- arm  input  1  single-cycle request to start watching for target
- clear  input  1  single-cycle request to drop hit and return to IDLE
- stable_cnt  output  WIDTH  last accepted (filtered) count value
- valid  output  1  high once at least one value has been accepted since reset
- match_pulse  output  1  one-cycle pulse when an accepted value equals the latched target while ARMED
- hit  output  1  level; high in state HIT
- busy  output  1  level; high in state ARMED
- wrap_cnt  output  WRAP_CNT_W  number of wrap-arounds seen, saturating

## Operation
- Synchronizer: count_in passes through SYNC_STAGES flops (all bits in parallel); the last stage output is s_cnt.
- Filter: s_prev holds s_cnt delayed one cycle. A candidate is accepted when s_cnt == s_prev and s_cnt != stable_cnt, or on the first equal pair after reset.
  - On acceptance, stable_cnt <= s_cnt and valid <= 1.
  - An unequal pair is never accepted, which rejects ripple transients.
- Target latch: tgt_q <= target on any cycle with arm high in IDLE. Arm in ARMED or HIT is ignored.
- FSM states: IDLE, ARMED, HIT.
  - IDLE → ARMED on arm.
  - ARMED → HIT on acceptance with new value == tgt_q. match_pulse is high for exactly that one cycle.
  - ARMED → IDLE on clear.
  - HIT → IDLE on clear.
  - HIT holds otherwise. Further matches in HIT produce no pulse.
- Priority: clear beats arm and beats a match in the same cycle. Match-and-clear in ARMED gives IDLE with no pulse.
- Arming when stable_cnt already equals target does not hit. A fresh acceptance of that value is required.
- Wrap detect: on acceptance where the old stable_cnt == all-ones and the new value == 0, wrap_cnt increments. It saturates at all-ones and never rolls over.
- Skipped values (e.g. 14→1 due to a slow clk) are not wraps.
- Outputs are registered. No combinational path runs from inputs to outputs.

## Timing
- Reset values: stable_cnt=0, valid=0, match_pulse=0, hit=0, busy=0, wrap_cnt=0, state=IDLE, tgt_q=0. All synchronizer and filter flops are 0.
- Latency from a settled count_in change to stable_cnt update is SYNC_STAGES+2 clk edges (4 with defaults).
- match_pulse and the HIT transition occur on the same edge as the stable_cnt update. hit rises on that edge.
- wrap_cnt updates on the same edge as stable_cnt.
- The minimum count_in hold for guaranteed acceptance is 2 clk periods after settling. Shorter values may be dropped.
- Reset asserted mid-operation immediately forces all reset values. After deassertion, valid re-arms on the first stable pair.

## Configuration
- Macro RIPPLE_MON_WRAP_CNT_EN.
  - Defined: the wrap detector and the WRAP_CNT_W counter are built as described.
  - Undefined: no wrap logic is synthesized and wrap_cnt is driven constant 0.
- All other behaviour is identical either way.

## Structure
- Shared package/include ripple_mon_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_ARMED=2'd1, ST_HIT=2'd2
  - the minimum SYNC_STAGES constant
- One sub-module, sync_chain: a parameterized WIDTH×SYNC_STAGES flop chain with async active-high reset.
- Filter, FSM and wrap counter live in the top module.

## Test plan
- Reset: hold rst with count_in=4'hA → all outputs 0. Release, hold 4'hA → stable_cnt=4'hA and valid=1 four edges later.
- Glitch reject: count_in 3→4 with one-cycle transients 7 and 5 in between → stable_cnt goes 3→4 only, never 7 or 5.
- Match: arm with target=9, step the count 6,7,8,9 (3 cycles each) → a single match_pulse on the edge stable_cnt becomes 9. hit=1 and busy=0 after it, and a second pass through 9 gives no pulse.
- Clear priority: in ARMED, assert clear on the acceptance edge of target → state IDLE, no pulse, hit=0.
- Wrap: run 16 full cycles 0..15..0 → wrap_cnt=16. With WRAP_CNT_W=4, 20 wraps → wrap_cnt=15 (saturated). Without RIPPLE_MON_WRAP_CNT_EN → wrap_cnt stays 0.
- Async reset mid-HIT: assert rst between clock edges → hit, wrap_cnt and stable_cnt read 0 before the next clk edge.

Source files
------------

// File: rtl/ripple_mon_pkg.sv
// ============================================================================
//  Module   : ripple_mon_pkg
//  Purpose  : Shared types and constants for the ripple counter monitor.
//             Holds the FSM state encoding and the minimum synchronizer
//             depth.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ripple_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIT   = 2'd2
  } state_t;

  // Fewer than two flops does not give metastability protection.
  localparam int SYNC_STAGES_MIN = 2;

endpackage

`default_nettype wire

// File: rtl/ripple_count_monitor_if.sv
// ============================================================================
//  Module   : ripple_count_monitor_if
//  Purpose  : Groups the monitor's data and control signals.
//             master drives count/target/arm/clear; slave (the monitor)
//             drives the filtered count, status and wrap counter.
//  Ports    : none (interface); parameters WIDTH, WRAP_CNT_W
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ripple_count_monitor_if #(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8
);

  logic [WIDTH-1:0]      count_in;
  logic [WIDTH-1:0]      target;
  logic                  arm;
  logic                  clear;
  logic [WIDTH-1:0]      stable_cnt;
  logic                  valid;
  logic                  match_pulse;
  logic                  hit;
  logic                  busy;
  logic [WRAP_CNT_W-1:0] wrap_cnt;

  modport master (
    output count_in, target, arm, clear,
    input  stable_cnt, valid, match_pulse, hit, busy, wrap_cnt
  );

  modport slave (
    input  count_in, target, arm, clear,
    output stable_cnt, valid, match_pulse, hit, busy, wrap_cnt
  );

endinterface

`default_nettype wire

// File: rtl/ripple_count_monitor_sync_chain.sv
// ============================================================================
//  Module   : sync_chain
//  Purpose  : WIDTH-bit wide, STAGES-deep flop chain bringing an
//             asynchronous bus into the clk domain (all bits in parallel).
//  Ports    : clk  - system clock
//             rst  - asynchronous active-high reset, clears every stage
//             d_i  - asynchronous input bus
//             q_o  - output of the last stage
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ripple_count_monitor.sv
// ============================================================================
//  Module   : ripple_count_monitor
//  Purpose  : Resamples a ripple counter, accepts only values seen equal on
//             two consecutive synchronized samples, flags a programmable
//             target through an IDLE/ARMED/HIT FSM and optionally counts
//             all-ones -> zero wrap-arounds.
//  Ports    : clk  - system clock
//             rst  - asynchronous active-high reset
//             bus  - ripple_count_monitor_if.slave
//                    (count_in, target, arm, clear in;
//                     stable_cnt, valid, match_pulse, hit, busy, wrap_cnt out)
//  Config   : RIPPLE_MON_WRAP_CNT_EN - when defined, builds the saturating
//             wrap counter; otherwise wrap_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ripple_count_monitor_if.slave  bus
);

  // Depth is clamped so a too-small parameter still yields a real synchronizer.
  localparam int STAGES   = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  // Samples needed before s_cnt and s_prev both hold post-reset input data.
  localparam int FILL_MAX = STAGES + 1;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);

  logic [WIDTH-1:0]  s_cnt;
  logic [WIDTH-1:0]  s_prev_q;
  logic [WIDTH-1:0]  stable_q;
  logic [WIDTH-1:0]  tgt_q;
  logic [FILL_W-1:0] fill_q;
  logic              valid_q;
  logic              match_pulse_q;
  logic              hit_q;
  logic              busy_q;
  state_t            state_q;

  logic              primed;
  logic              accept;
  logic              is_match;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.count_in),
    .q_o (s_cnt)
  );

  // The zeros flushed out of the reset pipeline must not be mistaken for a
  // stable pair, so the filter only looks at pairs once the chain has filled.
  assign primed   = (fill_q == FILL_W'(FILL_MAX));
  assign accept   = primed && (s_cnt == s_prev_q) && (!valid_q || (s_cnt != stable_q));
  assign is_match = accept && (s_cnt == tgt_q);

  // Glitch filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q   <= '0;
      s_prev_q <= '0;
      stable_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      s_prev_q <= s_cnt;
      if (!primed) begin
        fill_q <= fill_q + FILL_W'(1);
      end
      if (accept) begin
        stable_q <= s_cnt;
        valid_q  <= 1'b1;
      end
    end
  end

  // Arm/hit FSM; clear always wins over arm and over a match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tgt_q         <= '0;
      match_pulse_q <= 1'b0;
      hit_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      match_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.arm) begin
            tgt_q <= bus.target;
          end
          if (bus.arm && !bus.clear) begin
            state_q <= ST_ARMED;
            busy_q  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (bus.clear) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (is_match) begin
            state_q       <= ST_HIT;
            busy_q        <= 1'b0;
            hit_q         <= 1'b1;
            match_pulse_q <= 1'b1;
          end
        end
        ST_HIT: begin
          if (bus.clear) begin
            state_q <= ST_IDLE;
            hit_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hit_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RIPPLE_MON_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_q;
  logic [WRAP_CNT_W-1:0] wrap_d;

  // Only a direct all-ones -> zero step counts; skipped values do not.
  always_comb begin
    wrap_d = wrap_q;
    if (accept && (stable_q == '1) && (s_cnt == '0) && (wrap_q != '1)) begin
      wrap_d = wrap_q + WRAP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.wrap_cnt = wrap_q;
`else
  assign bus.wrap_cnt = '0;
`endif

  assign bus.stable_cnt  = stable_q;
  assign bus.valid       = valid_q;
  assign bus.match_pulse = match_pulse_q;
  assign bus.hit         = hit_q;
  assign bus.busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ripple_count_monitor.sv
// ============================================================================
//  Module   : tb_ripple_count_monitor
//  Purpose  : Self-checking bench for ripple_count_monitor. Stimulus pushes
//             each expected accepted value (with expected pulse and wrap
//             count) into a queue; a monitor pops on every acceptance seen
//             at the DUT outputs. A second instance with a 4-bit wrap
//             counter shares the count stream for saturation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ripple_count_monitor;

`ifdef RIPPLE_MON_WRAP_CNT_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] v;
    logic       p;
    logic [7:0] w;
  } exp_t;

  logic clk;
  logic rst;

  int tests;
  int fails;
  int model_last;
  int wrap_m;
  int wrap_sat_m;
  exp_t exp_q[$];

  ripple_count_monitor_if #(.WIDTH(4), .WRAP_CNT_W(8)) bus ();
  ripple_count_monitor_if #(.WIDTH(4), .WRAP_CNT_W(4)) bus_sat ();

  ripple_count_monitor #(.WIDTH(4), .SYNC_STAGES(2), .WRAP_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ripple_count_monitor #(.WIDTH(4), .SYNC_STAGES(2), .WRAP_CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  assign bus_sat.count_in = bus.count_in;
  assign bus_sat.target   = 4'h0;
  assign bus_sat.arm      = 1'b0;
  assign bus_sat.clear    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a count value for 'hold' cycles; values held >= 2 cycles are
  // expected to be accepted if they differ from the last accepted one.
  task automatic step(input logic [3:0] v, input int hold, input bit pulse);
    exp_t e;
    bus.count_in = v;
    if (hold >= 2 && int'(v) != model_last) begin
      if (model_last == 15 && v == 4'd0) begin
        if (wrap_m < 255) wrap_m++;
        if (wrap_sat_m < 15) wrap_sat_m++;
      end
      e.v = v;
      e.p = pulse;
      e.w = WRAP_EN ? 8'(wrap_m) : 8'd0;
      exp_q.push_back(e);
      model_last = int'(v);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic pulse_arm(input logic [3:0] t);
    bus.arm    = 1'b1;
    bus.target = t;
    @(negedge clk);
    bus.arm    = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    logic       prev_valid;
    logic [3:0] prev_stable;
    exp_t       e;
    prev_valid  = 1'b0;
    prev_stable = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_valid  = 1'b0;
        prev_stable = 4'h0;
      end else begin
        if (bus.valid && (!prev_valid || bus.stable_cnt != prev_stable)) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_accept: got %0h expected none", bus.stable_cnt);
          end else begin
            e = exp_q.pop_front();
            chk("sb_stable_cnt", 32'(bus.stable_cnt), 32'(e.v));
            chk("sb_match_pulse", 32'(bus.match_pulse), 32'(e.p));
            chk("sb_wrap_cnt", 32'(bus.wrap_cnt), 32'(e.w));
          end
        end else if (bus.match_pulse) begin
          tests++;
          fails++;
          $display("FAIL stray_match_pulse: got 1 expected 0 (stable %0h)", bus.stable_cnt);
        end
        prev_valid  = bus.valid;
        prev_stable = bus.stable_cnt;
      end
    end
  end

  initial begin
    tests      = 0;
    fails      = 0;
    model_last = -1;
    wrap_m     = 0;
    wrap_sat_m = 0;
    rst          = 1'b1;
    bus.count_in = 4'hA;
    bus.target   = 4'h0;
    bus.arm      = 1'b0;
    bus.clear    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_stable_cnt", 32'(bus.stable_cnt), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_match_pulse", 32'(bus.match_pulse), 32'h0);
    chk("rst_hit", 32'(bus.hit), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_wrap_cnt", 32'(bus.wrap_cnt), 32'h0);

    // Latency: valid rises exactly on the 4th edge after release
    rst = 1'b0;
    step(4'hA, 3, 1'b0);
    chk("lat_valid_3edges", 32'(bus.valid), 32'h0);
    @(negedge clk);
    chk("lat_valid_4edges", 32'(bus.valid), 32'h1);
    chk("lat_stable_4edges", 32'(bus.stable_cnt), 32'hA);

    // Glitch rejection: 3 -> (7,5 one cycle each) -> 4
    step(4'd3, 3, 1'b0);
    step(4'd7, 1, 1'b0);
    step(4'd5, 1, 1'b0);
    step(4'd4, 6, 1'b0);

    // Match on target 9
    pulse_arm(4'd9);
    chk("arm_busy", 32'(bus.busy), 32'h1);
    step(4'd6, 3, 1'b0);
    step(4'd7, 3, 1'b0);
    step(4'd8, 3, 1'b0);
    step(4'd9, 3, 1'b1);
    repeat (3) @(negedge clk);
    chk("match_hit", 32'(bus.hit), 32'h1);
    chk("match_busy", 32'(bus.busy), 32'h0);
    step(4'd10, 3, 1'b0);
    step(4'd9, 6, 1'b0);
    chk("hit_holds", 32'(bus.hit), 32'h1);
    pulse_clear();
    chk("clear_hit", 32'(bus.hit), 32'h0);

    // Arming on an already-held target value must not hit
    pulse_arm(4'd9);
    repeat (6) @(negedge clk);
    chk("prematch_hit", 32'(bus.hit), 32'h0);
    chk("prematch_busy", 32'(bus.busy), 32'h1);
    pulse_clear();
    chk("prematch_clear_busy", 32'(bus.busy), 32'h0);

    // Clear coincident with the acceptance edge of the target
    pulse_arm(4'd2);
    step(4'd2, 3, 1'b0);
    pulse_clear();
    repeat (2) @(negedge clk);
    chk("clrprio_hit", 32'(bus.hit), 32'h0);
    chk("clrprio_busy", 32'(bus.busy), 32'h0);

    // Arm and clear together in IDLE stays IDLE
    bus.arm   = 1'b1;
    bus.clear = 1'b1;
    bus.target = 4'd3;
    @(negedge clk);
    bus.arm   = 1'b0;
    bus.clear = 1'b0;
    chk("armclr_busy", 32'(bus.busy), 32'h0);

    // Wraps: 16 full passes, then a skip that is not a wrap
    for (int c = 0; c < 16; c++) begin
      for (int v = 0; v < 16; v++) begin
        step(4'(v), 2, 1'b0);
      end
    end
    step(4'd0, 2, 1'b0);
    step(4'd14, 3, 1'b0);
    step(4'd1, 6, 1'b0);
    chk("wrap16_main", 32'(bus.wrap_cnt), WRAP_EN ? 32'd16 : 32'd0);
    chk("wrap16_sat", 32'(bus_sat.wrap_cnt), WRAP_EN ? 32'd15 : 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(4'd15, 2, 1'b0);
      step(4'd0, 2, 1'b0);
    end
    repeat (4) @(negedge clk);
    chk("wrap20_main", 32'(bus.wrap_cnt), WRAP_EN ? 32'd20 : 32'd0);
    chk("wrap20_sat", 32'(bus_sat.wrap_cnt), WRAP_EN ? 32'd15 : 32'd0);

    // Asynchronous reset while in HIT
    pulse_arm(4'd5);
    step(4'd5, 3, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_arst_hit", 32'(bus.hit), 32'h1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_hit", 32'(bus.hit), 32'h0);
    chk("arst_wrap_cnt", 32'(bus.wrap_cnt), 32'h0);
    chk("arst_stable_cnt", 32'(bus.stable_cnt), 32'h0);
    chk("arst_valid", 32'(bus.valid), 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    model_last = -1;
    wrap_m     = 0;
    wrap_sat_m = 0;
    step(4'd5, 6, 1'b0);
    chk("post_arst_valid", 32'(bus.valid), 32'h1);

    repeat (4) @(negedge clk);
    chk("sb_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
